// File: rtl/pipe_fwd_ctrl.sv
// Scoreboard, operand forwarding and load-use interlock for an in-order pipeline.
// Tracks every in-flight instruction from issue to retire across STAGES post-issue stages.
module pipe_fwd_ctrl #(
  parameter  int DATA_W     = 32,
  parameter  int ADDR_W     = 5,
  parameter  int STAGES     = 3,
  parameter  int LOAD_STAGE = 2,
  localparam int SEL_W      = $clog2(STAGES + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     issue_valid,
  input  logic [ADDR_W-1:0]        issue_waddr,
  input  logic                     issue_wen,
  input  logic                     issue_load,
  input  logic                     flush,
  input  logic                     ext_stall,
  input  logic [ADDR_W-1:0]        rs_addr,
  input  logic                     rs_used,
  input  logic [ADDR_W-1:0]        rt_addr,
  input  logic                     rt_used,
  input  logic [DATA_W-1:0]        rf_rs_data,
  input  logic [DATA_W-1:0]        rf_rt_data,
  input  logic [STAGES*DATA_W-1:0] stage_data,
  output logic [DATA_W-1:0]        fwd_rs_data,
  output logic [DATA_W-1:0]        fwd_rt_data,
  output logic [SEL_W-1:0]         fwd_rs_sel,
  output logic [SEL_W-1:0]         fwd_rt_sel,
  output logic                     hz_stall,
  output logic [STAGES-1:0]        stage_valid,
  output logic [31:0]              retire_cnt,
  output logic [31:0]              stall_cnt
);

  logic [STAGES-1:0] ent_valid;
  logic [STAGES-1:0] ent_wen;
  logic [STAGES-1:0] ent_load;
  logic [ADDR_W-1:0] ent_waddr [STAGES];

  logic rs_load_hit;
  logic rt_load_hit;
  logic issue_ok;

  assign stage_valid = ent_valid;
  assign issue_ok    = issue_valid & ~flush & ~hz_stall;

  // Walk oldest to youngest so the youngest matching producer is the one left standing.
  always_comb begin
    fwd_rs_data = rf_rs_data;
    fwd_rt_data = rf_rt_data;
    fwd_rs_sel  = '0;
    fwd_rt_sel  = '0;
    rs_load_hit = 1'b0;
    rt_load_hit = 1'b0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (ent_valid[k] && ent_wen[k] && (ent_waddr[k] == rs_addr) && (rs_addr != '0)) begin
        fwd_rs_data = stage_data[k*DATA_W +: DATA_W];
        fwd_rs_sel  = SEL_W'(k + 1);
        rs_load_hit = ent_load[k] && (k < LOAD_STAGE);
      end
      if (ent_valid[k] && ent_wen[k] && (ent_waddr[k] == rt_addr) && (rt_addr != '0)) begin
        fwd_rt_data = stage_data[k*DATA_W +: DATA_W];
        fwd_rt_sel  = SEL_W'(k + 1);
        rt_load_hit = ent_load[k] && (k < LOAD_STAGE);
      end
    end
    hz_stall = (rs_used & rs_load_hit) | (rt_used & rt_load_hit);
  end

  // Entries shift one stage per advance; a stalled or flushed issue slot becomes a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      ent_valid  <= '0;
      ent_wen    <= '0;
      ent_load   <= '0;
      for (int k = 0; k < STAGES; k++) ent_waddr[k] <= '0;
      retire_cnt <= '0;
      stall_cnt  <= '0;
    end else if (!ext_stall) begin
      ent_valid <= {ent_valid[STAGES-2:0], issue_ok};
      ent_wen   <= {ent_wen[STAGES-2:0], issue_ok & issue_wen};
      ent_load  <= {ent_load[STAGES-2:0], issue_ok & issue_load};
      for (int k = 1; k < STAGES; k++) ent_waddr[k] <= ent_waddr[k-1];
      ent_waddr[0] <= issue_ok ? issue_waddr : '0;
      retire_cnt   <= retire_cnt + 32'(ent_valid[STAGES-1]);
      stall_cnt    <= stall_cnt + 32'(hz_stall);
    end
  end

endmodule

// File: tb/tb_pipe_fwd_ctrl.sv
// Directed-vector bench for pipe_fwd_ctrl with STAGES=3, LOAD_STAGE=2.
module tb_pipe_fwd_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic [4:0]  issue_waddr;
  logic        issue_wen;
  logic        issue_load;
  logic        flush;
  logic        ext_stall;
  logic [4:0]  rs_addr;
  logic        rs_used;
  logic [4:0]  rt_addr;
  logic        rt_used;
  logic [31:0] rf_rs_data;
  logic [31:0] rf_rt_data;
  logic [95:0] stage_data;
  logic [31:0] fwd_rs_data;
  logic [31:0] fwd_rt_data;
  logic [1:0]  fwd_rs_sel;
  logic [1:0]  fwd_rt_sel;
  logic        hz_stall;
  logic [2:0]  stage_valid;
  logic [31:0] retire_cnt;
  logic [31:0] stall_cnt;

  int vectors    = 0;
  int miscompares = 0;

  pipe_fwd_ctrl #(.DATA_W(32), .ADDR_W(5), .STAGES(3), .LOAD_STAGE(2)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_waddr(issue_waddr),
    .issue_wen(issue_wen), .issue_load(issue_load),
    .flush(flush), .ext_stall(ext_stall),
    .rs_addr(rs_addr), .rs_used(rs_used), .rt_addr(rt_addr), .rt_used(rt_used),
    .rf_rs_data(rf_rs_data), .rf_rt_data(rf_rt_data), .stage_data(stage_data),
    .fwd_rs_data(fwd_rs_data), .fwd_rt_data(fwd_rt_data),
    .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
    .hz_stall(hz_stall), .stage_valid(stage_valid),
    .retire_cnt(retire_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drives the decode-side issue fields and lets combinational outputs settle.
  task automatic applyStimulus(input logic v, input logic [4:0] a, input logic w, input logic l);
    issue_valid = v;
    issue_waddr = a;
    issue_wen   = w;
    issue_load  = l;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; ext_stall = 1'b0;
    rs_addr = 5'd3; rs_used = 1'b0; rt_addr = 5'd0; rt_used = 1'b0;
    rf_rs_data = 32'hAA; rf_rt_data = 32'h77; stage_data = '0;
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0);
    step();
    rst = 1'b0;
    #1;
    checkOutput("rst_valid", 32'(stage_valid), 32'd0);
    checkOutput("rst_retire", retire_cnt, 32'd0);
    checkOutput("rst_stall", stall_cnt, 32'd0);
    checkOutput("rst_fwd", fwd_rs_data, 32'hAA);
    checkOutput("rst_sel", 32'(fwd_rs_sel), 32'd0);
    checkOutput("rst_hz", 32'(hz_stall), 32'd0);

    // ALU chain
    applyStimulus(1'b1, 5'd3, 1'b1, 1'b0);
    step();
    rs_used = 1'b1;
    stage_data = {32'hBBBB, 32'hCCCC, 32'h1234};
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0);
    checkOutput("alu_fwd", fwd_rs_data, 32'h1234);
    checkOutput("alu_sel", 32'(fwd_rs_sel), 32'd1);
    checkOutput("alu_hz", 32'(hz_stall), 32'd0);
    checkOutput("alu_valid", 32'(stage_valid), 32'b001);

    // Priority: $3 in stage0 and stage2
    step();
    applyStimulus(1'b1, 5'd3, 1'b1, 1'b0);
    step();
    stage_data = {32'hB, 32'hC, 32'hA};
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0);
    checkOutput("prio_valid", 32'(stage_valid), 32'b101);
    checkOutput("prio_fwd", fwd_rs_data, 32'hA);
    checkOutput("prio_sel", 32'(fwd_rs_sel), 32'd1);
    step();
    applyStimulus(1'b1, 5'd3, 1'b0, 1'b0);
    step();
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0);
    checkOutput("drop_valid", 32'(stage_valid), 32'b101);
    checkOutput("drop_fwd", fwd_rs_data, 32'hB);
    checkOutput("drop_sel", 32'(fwd_rs_sel), 32'd3);
    step(); step(); step();
    checkOutput("drain_retire", retire_cnt, 32'd3);
    checkOutput("drain_valid", 32'(stage_valid), 32'd0);

    // Load-use interlock
    rs_used = 1'b0;
    applyStimulus(1'b1, 5'd5, 1'b1, 1'b1);
    step();
    rs_addr = 5'd5; rs_used = 1'b1;
    stage_data = {32'hD00D, 32'hE00E, 32'hF00F};
    applyStimulus(1'b1, 5'd7, 1'b1, 1'b0);
    checkOutput("lu_hz0", 32'(hz_stall), 32'd1);
    step();
    #1;
    checkOutput("lu_hz1", 32'(hz_stall), 32'd1);
    checkOutput("lu_bubble", 32'(stage_valid), 32'b010);
    step();
    #1;
    checkOutput("lu_hz2", 32'(hz_stall), 32'd0);
    checkOutput("lu_sel", 32'(fwd_rs_sel), 32'd3);
    checkOutput("lu_fwd", fwd_rs_data, 32'hD00D);
    checkOutput("lu_stallcnt", stall_cnt, 32'd2);
    checkOutput("lu_valid", 32'(stage_valid), 32'b100);
    step();
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0);
    checkOutput("lu_retire", retire_cnt, 32'd4);
    checkOutput("lu_stallhold", stall_cnt, 32'd2);

    // Register 0 never forwarded
    applyStimulus(1'b1, 5'd0, 1'b1, 1'b0);
    step();
    rs_addr = 5'd0; rs_used = 1'b1; rf_rs_data = 32'h55;
    applyStimulus(1'b1, 5'd6, 1'b1, 1'b1);
    checkOutput("r0_sel", 32'(fwd_rs_sel), 32'd0);
    checkOutput("r0_fwd", fwd_rs_data, 32'h55);
    step();
    // Unused rt with pending load
    rs_used = 1'b0; rt_addr = 5'd6; rt_used = 1'b0;
    stage_data = {32'h3, 32'h2, 32'h6666};
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0);
    checkOutput("unused_hz", 32'(hz_stall), 32'd0);
    checkOutput("unused_sel", 32'(fwd_rt_sel), 32'd1);
    checkOutput("unused_fwd", fwd_rt_data, 32'h6666);
    rt_used = 1'b1;
    #1;
    checkOutput("used_rt_hz", 32'(hz_stall), 32'd1);
    rt_used = 1'b0;
    #1;
    step(); step();
    checkOutput("pre_freeze_retire", retire_cnt, 32'd6);

    // Freeze with a pending load-use and flush asserted
    applyStimulus(1'b1, 5'd10, 1'b1, 1'b0);
    step();
    applyStimulus(1'b1, 5'd11, 1'b1, 1'b0);
    step();
    applyStimulus(1'b1, 5'd9, 1'b1, 1'b1);
    step();
    checkOutput("fill_valid", 32'(stage_valid), 32'b111);
    checkOutput("fill_retire", retire_cnt, 32'd7);
    rs_addr = 5'd9; rs_used = 1'b1; ext_stall = 1'b1; flush = 1'b1;
    applyStimulus(1'b1, 5'd12, 1'b1, 1'b0);
    checkOutput("frz_hz", 32'(hz_stall), 32'd1);
    step(); step(); step();
    checkOutput("frz_valid", 32'(stage_valid), 32'b111);
    checkOutput("frz_retire", retire_cnt, 32'd7);
    checkOutput("frz_stall", stall_cnt, 32'd2);
    rs_used = 1'b0; ext_stall = 1'b0;
    applyStimulus(1'b1, 5'd12, 1'b1, 1'b0);
    step();
    flush = 1'b0;
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0);
    checkOutput("flush_bubble", 32'(stage_valid), 32'b110);
    checkOutput("rel_retire1", retire_cnt, 32'd8);
    step(); step();
    checkOutput("rel_retire3", retire_cnt, 32'd10);
    checkOutput("rel_valid", 32'(stage_valid), 32'd0);

    // Reset mid-operation
    applyStimulus(1'b1, 5'd4, 1'b1, 1'b0);
    step();
    rst = 1'b1;
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0);
    step();
    rst = 1'b0;
    #1;
    checkOutput("mid_rst_valid", 32'(stage_valid), 32'd0);
    checkOutput("mid_rst_retire", retire_cnt, 32'd0);
    checkOutput("mid_rst_stall", stall_cnt, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
